// File: rtl/onchip_mem_pkg.sv
// Shared defaults and types for the on-chip pattern memory arbiter.
package onchip_mem_pkg;

   localparam int unsigned ADDR_W = 13;
   localparam int unsigned DATA_W = 256;
   localparam int unsigned BE_W   = 32;
   localparam int unsigned RD_LAT = 1;

   // Requester identifiers carried in the read-return tag
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef struct packed {
      logic valid;
      logic port;
   } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift pipe that delays read tags until the memory returns data.
module rd_tag_pipe #(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  onchip_mem_pkg::rd_tag_t  i_tag,
   output onchip_mem_pkg::rd_tag_t  o_tag
);

   import onchip_mem_pkg::*;

   rd_tag_t [DEPTH-1:0] r_stage;

   // Shift one stage per cycle; reset drops every in-flight tag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stage <= '0;
      end else begin
         r_stage <= {r_stage[DEPTH-2:0], i_tag};
      end
   end

   assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-port arbiter/sequencer for the single-port pattern memory. Port A (display fetch)
// normally wins; port B (host loader) is forced through after MAX_WAIT blocked cycles.
module onchip_mem_arbiter #(
   parameter int unsigned ADDR_W   = onchip_mem_pkg::ADDR_W,
   parameter int unsigned DATA_W   = onchip_mem_pkg::DATA_W,
   parameter int unsigned BE_W     = onchip_mem_pkg::BE_W,
   parameter int unsigned RD_LAT   = onchip_mem_pkg::RD_LAT,
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   // Port A: read-only fetcher
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   output logic              a_gnt,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_rvalid,
   // Port B: read/write loader
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   input  logic [BE_W-1:0]   b_be,
   output logic              b_gnt,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_rvalid,
   // Memory macro
   output logic              mem_cs,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic              mem_clken,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [BE_W-1:0]   mem_be,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       b_block_cnt
);

   import onchip_mem_pkg::*;

   localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

   logic [7:0]        r_wcnt;
   logic [15:0]       r_block_cnt;
   logic              r_cs;
   logic              r_rd;
   logic              r_wr;
   logic              r_clken;
   logic [ADDR_W-1:0] r_addr;
   logic [BE_W-1:0]   r_be;
   logic [DATA_W-1:0] r_wdata;

   logic              w_a_win;
   logic              w_b_win;
   rd_tag_t           w_tag_in;
   rd_tag_t           w_tag_out;

   // Winner select; no grants are issued while reset is held
   always_comb begin
      w_a_win = 1'b0;
      w_b_win = 1'b0;
      if (rst_n) begin
         w_a_win = a_req & (~b_req | (r_wcnt < WAIT_MAX));
         w_b_win = b_req & ~w_a_win;
      end
   end

   assign a_gnt = w_a_win;
   assign b_gnt = w_b_win;

   // Starvation counter: counts B's blocked cycles, saturates at MAX_WAIT, clears on B grant
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wcnt <= '0;
      end else if (w_b_win) begin
         r_wcnt <= '0;
      end else if (b_req && (r_wcnt < WAIT_MAX)) begin
         r_wcnt <= r_wcnt + 8'd1;
      end
   end

   // Diagnostic count of B's blocked cycles, saturating, cleared only by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_block_cnt <= '0;
      end else if (b_req && !w_b_win && (r_block_cnt != 16'hFFFF)) begin
         r_block_cnt <= r_block_cnt + 16'd1;
      end
   end

   // Register the granted command onto the memory pins
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_clken <= 1'b0;
         r_cs    <= 1'b0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
      end else begin
         r_clken <= 1'b1;
         r_cs    <= w_a_win | w_b_win;
         r_rd    <= w_a_win | (w_b_win & ~b_we);
         r_wr    <= w_b_win & b_we;
         r_be    <= '0;
         if (w_a_win) begin
            r_addr <= a_addr;
         end else if (w_b_win) begin
            r_addr <= b_addr;
            if (b_we) begin
               r_be    <= b_be;
               r_wdata <= b_wdata;
            end
         end
      end
   end

   // Tag for the read issued this cycle, pushed at grant time
   always_comb begin
      w_tag_in       = '0;
      w_tag_in.valid = w_a_win | (w_b_win & ~b_we);
      w_tag_in.port  = w_b_win ? PORT_B : PORT_A;
   end

   rd_tag_pipe #(
      .DEPTH (RD_LAT + 1)
   ) u_rd_tag_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .i_tag (w_tag_in),
      .o_tag (w_tag_out)
   );

   assign a_rvalid    = w_tag_out.valid & (w_tag_out.port == PORT_A);
   assign b_rvalid    = w_tag_out.valid & (w_tag_out.port == PORT_B);
   assign a_rdata     = mem_rdata;
   assign b_rdata     = mem_rdata;

   assign mem_cs      = r_cs;
   assign mem_rd      = r_rd;
   assign mem_wr      = r_wr;
   assign mem_clken   = r_clken;
   assign mem_addr    = r_addr;
   assign mem_be      = r_be;
   assign mem_wdata   = r_wdata;
   assign b_block_cnt = r_block_cnt;

endmodule
